// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA line prefetcher.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DRAIN
  } prefetch_state_t;

  localparam logic [31:0] FB_BASE_DEFAULT = 32'h3E80;
  localparam logic [3:0]  BYTE_SEL_ALL    = 4'b1111;

endpackage

// File: rtl/vga_word_fifo.sv
// Small prefetch FIFO with a registered head word. The head holds its
// last value whenever the FIFO is empty, including after a flush.
module vga_word_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          flush,
  input  logic [DATA_W-1:0]             wdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic [DATA_W-1:0]             head
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] next_head;
  logic              do_push, do_pop;

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = head_q;

  // Next pointers, occupancy and head word for the coming cycle.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    rd_ptr_d  = rd_ptr_q + PTR_W'(do_pop);
    wr_ptr_d  = wr_ptr_q + PTR_W'(do_push);
    count_d   = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    next_head = mem_q[rd_ptr_d];
    head_d    = head_q;
    // The slot that becomes the head may be the one written this cycle.
    if (do_push && (wr_ptr_q == rd_ptr_d)) begin
      next_head = wdata;
    end
    if (count_d != '0) begin
      head_d = next_head;
    end
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      head_d   = head_q;
    end
  end

  // Pointer, count and head registers.
  always_ff @(posedge clk or negedge nrst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!nrst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; empty slots are never read because count gates the head.
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/vga_line_prefetcher.sv
// Streams framebuffer words from SRAM into a prefetch FIFO for the VGA
// pixel pipeline. Restarts at FB_BASE on frame_start, wraps at frame end.
// Optional statistics counters are enabled with VGA_PREFETCH_STATS_EN.
module vga_line_prefetcher
  import vga_pkg::*;
#(
  parameter int              DATA_W          = 32,
  parameter int              ADDR_W          = 32,
  parameter int              FIFO_DEPTH      = 4,
  parameter int              WORDS_PER_FRAME = 9600,
  parameter logic [ADDR_W-1:0] FB_BASE       = ADDR_W'(FB_BASE_DEFAULT)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              frame_start,
  input  logic              pix_req,
  output logic [DATA_W-1:0] word_out,
  output logic              word_valid,
  output logic              underflow,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_byte_sel,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef VGA_PREFETCH_STATS_EN
  ,
  output logic [15:0]       underflow_count,
  output logic [15:0]       frame_count
`endif
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int WCNT_W = $clog2(WORDS_PER_FRAME + 1);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS_PER_FRAME - 1);

  prefetch_state_t   state_q, state_d;
  logic              mem_read_q, mem_read_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        byte_sel_q, byte_sel_d;
  logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
  logic              underflow_q, underflow_d;

  logic              fifo_push, fifo_pop, fifo_flush;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              ack_ok, uf_evt, full_after;

  vga_word_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (mem_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (word_out)
  );

  assign word_valid   = !fifo_empty;
  assign underflow    = underflow_q;
  assign mem_read     = mem_read_q;
  assign mem_addr     = mem_addr_q;
  assign mem_byte_sel = byte_sel_q;

  assign fifo_pop   = pix_req && word_valid;
  assign ack_ok     = mem_ack && mem_read_q;
  assign uf_evt     = pix_req && fifo_empty;
  // Occupancy after this cycle's push (always one in FETCH) and any pop.
  assign full_after = fifo_pop ? (fifo_count == CNT_W'(FIFO_DEPTH))
                               : (fifo_count == CNT_W'(FIFO_DEPTH - 1));

  // Next-state and next-output logic for the fetch controller.
  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_addr_d  = mem_addr_q;
    word_cnt_d  = word_cnt_q;
    fifo_push   = 1'b0;
    fifo_flush  = 1'b0;
    underflow_d = frame_start ? uf_evt : (underflow_q | uf_evt);
    unique case (state_q)
      IDLE, HOLD: begin
        if (frame_start) begin
          fifo_flush = 1'b1;
          word_cnt_d = '0;
          mem_addr_d = FB_BASE;
          mem_read_d = 1'b1;
          state_d    = FETCH;
        end else if ((state_q == HOLD) && !fifo_full) begin
          mem_read_d = 1'b1;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        if (frame_start) begin
          // Restart; an ack landing now belongs to the old frame and is dropped.
          fifo_flush = 1'b1;
          word_cnt_d = '0;
          if (ack_ok) begin
            mem_addr_d = FB_BASE;
          end else begin
            state_d = DRAIN;
          end
        end else if (ack_ok) begin
          fifo_push = 1'b1;
          if (word_cnt_q == LAST_WORD) begin
            word_cnt_d = '0;
            mem_addr_d = FB_BASE;
          end else begin
            word_cnt_d = word_cnt_q + WCNT_W'(1);
            mem_addr_d = mem_addr_q + ADDR_W'(1);
          end
          if (full_after) begin
            mem_read_d = 1'b0;
            state_d    = HOLD;
          end
        end
      end
      DRAIN: begin
        // Keep the stale request up until SRAM answers, then discard its data.
        if (frame_start) begin
          fifo_flush = 1'b1;
        end
        if (ack_ok) begin
          word_cnt_d = '0;
          mem_addr_d = FB_BASE;
          state_d    = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    byte_sel_d = mem_read_d ? BYTE_SEL_ALL : 4'b0000;
  end

  // Controller state and registered SRAM request outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_addr_q  <= FB_BASE;
      byte_sel_q  <= 4'b0000;
      word_cnt_q  <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_addr_q  <= mem_addr_d;
      byte_sel_q  <= byte_sel_d;
      word_cnt_q  <= word_cnt_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef VGA_PREFETCH_STATS_EN
  logic [15:0] ucnt_q, ucnt_d;
  logic [15:0] fcnt_q, fcnt_d;

  assign underflow_count = ucnt_q;
  assign frame_count     = fcnt_q;

  // Saturating underflow counter (per frame) and wrapping frame counter.
  always_comb begin
    ucnt_d = ucnt_q;
    fcnt_d = fcnt_q;
    if (frame_start) begin
      ucnt_d = uf_evt ? 16'd1 : 16'd0;
      fcnt_d = fcnt_q + 16'd1;
    end else if (uf_evt && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ucnt_q <= '0;
      fcnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
      fcnt_q <= fcnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_vga_line_prefetcher.sv
// Directed bench for vga_line_prefetcher with a word scoreboard and an
// SRAM model that returns each word's own address as data.
module tb_vga_line_prefetcher;

  localparam int          DATA_W = 32;
  localparam int          ADDR_W = 32;
  localparam int          DEPTH  = 4;
  localparam int          WPF    = 9600;
  localparam logic [31:0] BASE   = 32'h3E80;

  logic              clk = 1'b0;
  logic              nrst = 1'b1;
  logic              frame_start = 1'b0;
  logic              pix_req = 1'b0;
  logic              mem_ack = 1'b0;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] word_out;
  logic              word_valid, underflow, mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_byte_sel;
`ifdef VGA_PREFETCH_STATS_EN
  logic [15:0]       underflow_count, frame_count;
`endif

  logic              rdata_override = 1'b0;

  vga_line_prefetcher #(
    .DATA_W          (DATA_W),
    .ADDR_W          (ADDR_W),
    .FIFO_DEPTH      (DEPTH),
    .WORDS_PER_FRAME (WPF),
    .FB_BASE         (BASE)
  ) dut (
    .clk             (clk),
    .nrst            (nrst),
    .frame_start     (frame_start),
    .pix_req         (pix_req),
    .word_out        (word_out),
    .word_valid      (word_valid),
    .underflow       (underflow),
    .mem_read        (mem_read),
    .mem_addr        (mem_addr),
    .mem_byte_sel    (mem_byte_sel),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata)
`ifdef VGA_PREFETCH_STATS_EN
    ,
    .underflow_count (underflow_count),
    .frame_count     (frame_count)
`endif
  );

  always #5 clk = ~clk;

  // SRAM model: data equals the requested address unless a stale value is forced.
  assign mem_rdata = rdata_override ? 32'h0000_DEAD : mem_addr;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_word;
  logic        exp_uf;
  int          exp_idx;
  logic        draining;
  int          pops;
  logic        accepted_last;
  logic [15:0] exp_ucnt, exp_fcnt;
  logic        got;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    last_word = '0;
    exp_uf    = 1'b0;
    exp_idx   = 0;
    draining  = 1'b0;
    exp_ucnt  = '0;
    exp_fcnt  = '0;
  endtask

  // Assert reset right now, check reset values immediately, release on a falling edge.
  task automatic do_reset();
    nrst = 1'b0;
    frame_start = 1'b0;
    pix_req = 1'b0;
    mem_ack = 1'b0;
    rdata_override = 1'b0;
    #1;
    chk("rst_word_out", word_out, 32'h0);
    chk("rst_word_valid", 32'(word_valid), 32'h0);
    chk("rst_underflow", 32'(underflow), 32'h0);
    chk("rst_mem_read", 32'(mem_read), 32'h0);
    chk("rst_mem_addr", mem_addr, BASE);
    chk("rst_byte_sel", 32'(mem_byte_sel), 32'h0);
    reset_model();
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  // Wait for the falling edge and compare outputs against the model.
  task automatic tick();
    @(negedge clk);
    chk("word_valid", 32'(word_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("word_out", word_out, exp_q[0]);
    else                   chk("word_hold", word_out, last_word);
    chk("underflow", 32'(underflow), 32'(exp_uf));
`ifdef VGA_PREFETCH_STATS_EN
    chk("underflow_count", 32'(underflow_count), 32'(exp_ucnt));
    chk("frame_count", 32'(frame_count), 32'(exp_fcnt));
`endif
  endtask

  // Drive one cycle of inputs and advance the model to match the coming edge.
  task automatic drive(input logic fs, input logic pr, input logic ack);
    logic uf_evt, acc;
    frame_start = fs;
    pix_req     = pr;
    mem_ack     = ack;
    uf_evt = pr && (exp_q.size() == 0);
    acc    = ack && mem_read;
    accepted_last = acc;
    if (pr && (exp_q.size() != 0)) begin
      void'(exp_q.pop_front());
      pops++;
    end
    if (acc && !fs) begin
      if (draining) begin
        draining = 1'b0;
      end else begin
        chk("ack_addr", mem_addr, BASE + 32'(exp_idx));
        chk("ack_byte_sel", 32'(mem_byte_sel), 32'hF);
        exp_q.push_back(BASE + 32'(exp_idx));
        exp_idx = (exp_idx == WPF - 1) ? 0 : exp_idx + 1;
      end
    end
    if (fs) begin
      exp_q.delete();
      exp_idx  = 0;
      exp_uf   = uf_evt;
      draining = mem_read && !ack;
      exp_ucnt = uf_evt ? 16'd1 : 16'd0;
      exp_fcnt = exp_fcnt + 16'd1;
    end else begin
      exp_uf = exp_uf | uf_evt;
      if (uf_evt && (exp_ucnt != 16'hFFFF)) exp_ucnt = exp_ucnt + 16'd1;
    end
    if (exp_q.size() != 0) last_word = exp_q[0];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pops = 0;
    accepted_last = 1'b0;
    reset_model();
    #2;
    do_reset();

    // Fill after frame_start with ack held: four reads, then hold.
    tick(); drive(1'b1, 1'b0, 1'b1);
    repeat (4) begin tick(); drive(1'b0, 1'b0, 1'b1); end
    tick();
    chk("fill_hold_read", 32'(mem_read), 32'h0);
    chk("fill_hold_bsel", 32'(mem_byte_sel), 32'h0);
    chk("fill_next_addr", mem_addr, BASE + 32'd4);
    drive(1'b0, 1'b0, 1'b1);
    tick();
    chk("first_word", word_out, BASE);
    drive(1'b0, 1'b1, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick(); drive(1'b0, 1'b0, 1'b1);
      got = accepted_last;
    end
    chk("refill_read", 32'(got), 32'h1);

    // Push and pop together while fetching keeps occupancy and order.
    tick(); drive(1'b0, 1'b1, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (mem_read) begin drive(1'b0, 1'b1, 1'b1); got = 1'b1; end
      else          drive(1'b0, 1'b0, 1'b0);
    end
    chk("refetch_seen", 32'(got), 32'h1);
    repeat (2) begin tick(); drive(1'b0, 1'b1, 1'b1); end
    tick();
    chk("fetch_keep", 32'(mem_read), 32'h1);
    drive(1'b0, 1'b0, 1'b1);
    tick();
    chk("hold_again", 32'(mem_read), 32'h0);
    drive(1'b0, 1'b0, 1'b0);

    // Whole frame plus wrap, one pull every fourth cycle.
    tick(); drive(1'b1, 1'b0, 1'b1);
    pops = 0;
    for (int i = 0; i < 45000 && pops < WPF + 2; i++) begin
      tick(); drive(1'b0, (i % 4) == 3, 1'b1);
    end
    chk("frame_words", pops, WPF + 2);

    // Underflow with ack withheld, then frame_start during an outstanding read.
    do_reset();
    tick(); drive(1'b1, 1'b0, 1'b0);
    tick(); drive(1'b0, 1'b0, 1'b1);
    tick(); drive(1'b0, 1'b1, 1'b0);
    tick(); drive(1'b0, 1'b1, 1'b0);
    tick();
    chk("uf_set", 32'(underflow), 32'h1);
    chk("uf_word_kept", word_out, BASE);
    drive(1'b0, 1'b0, 1'b0);
    repeat (6) begin tick(); drive(1'b0, 1'b1, 1'b1); end
    tick();
    chk("pending_addr", mem_addr, BASE + 32'd7);
    rdata_override = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    tick();
    chk("drain_read", 32'(mem_read), 32'h1);
    chk("drain_addr", mem_addr, BASE + 32'd7);
    chk("uf_cleared", 32'(underflow), 32'h0);
    drive(1'b0, 1'b0, 1'b0);
    tick(); drive(1'b0, 1'b0, 1'b0);
    tick(); drive(1'b0, 1'b0, 1'b1);
    tick();
    rdata_override = 1'b0;
    chk("restart_addr", mem_addr, BASE);
    chk("restart_read", 32'(mem_read), 32'h1);
    chk("drain_no_word", 32'(word_valid), 32'h0);
    drive(1'b0, 1'b0, 1'b1);
    tick(); drive(1'b0, 1'b1, 1'b0);
    tick(); drive(1'b0, 1'b0, 1'b0);

    // Statistics: three underflows, then a frame restart.
    do_reset();
    tick(); drive(1'b1, 1'b0, 1'b0);
    repeat (3) begin tick(); drive(1'b0, 1'b1, 1'b0); end
    tick();
`ifdef VGA_PREFETCH_STATS_EN
    chk("stats_ucnt3", 32'(underflow_count), 32'd3);
    chk("stats_fcnt1", 32'(frame_count), 32'd1);
`endif
    drive(1'b1, 1'b0, 1'b0);
    tick();
`ifdef VGA_PREFETCH_STATS_EN
    chk("stats_ucnt0", 32'(underflow_count), 32'd0);
    chk("stats_fcnt2", 32'(frame_count), 32'd2);
`endif
    drive(1'b0, 1'b0, 1'b0);

    // Reset in the middle of streaming.
    tick(); drive(1'b1, 1'b0, 1'b1);
    repeat (3) begin tick(); drive(1'b0, 1'b1, 1'b1); end
    @(posedge clk);
    #2;
    do_reset();
    repeat (3) begin tick(); drive(1'b0, 1'b0, 1'b1); end
    tick();
    chk("post_rst_idle", 32'(mem_read), 32'h0);
    drive(1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_line_prefetcher.md
Name: vga_line_prefetcher

Overview:
- Parametrised successor of the single-register VGA word controller.
- Streams framebuffer words from SRAM into a small prefetch FIFO, so the VGA pixel pipeline pulls one word per request without stalling on SRAM latency.
- Sits between the SRAM arbiter port and the VGA pixel serializer.
- Restarts at the framebuffer base on every frame start and wraps the address at frame end.

Parameters:
- DATA_W, 32: SRAM/VGA word width in bits.
- ADDR_W, 32: SRAM word-address width.
- FIFO_DEPTH, 4: prefetch FIFO entries; must be a power of two and ≥2.
- WORDS_PER_FRAME, 9600: framebuffer length in words.
- FB_BASE, 32'h3E80: first word address of the framebuffer.

Ports:
- clk  in  1  system clock
- nrst  in  1  reset, asynchronous, active-low
- frame_start  in  1  single-cycle pulse at start of vertical blank; flushes and restarts the prefetch
- pix_req  in  1  VGA pulls one word this cycle
- word_out  out  DATA_W  head-of-FIFO word, registered
- word_valid  out  1  FIFO non-empty
- underflow  out  1  sticky; set by pix_req while the FIFO is empty, cleared by frame_start
- mem_read  out  1  read request to SRAM
- mem_addr  out  ADDR_W  word address of the request
- mem_byte_sel  out  4  byte lanes; constant 4'b1111 whenever mem_read=1, 0 otherwise
- mem_ack  in  1  SRAM accepted the request and returns mem_rdata this cycle
- mem_rdata  in  DATA_W  read data, valid with mem_ack

Behaviour:
- Reset values:
  - outputs: word_out=0, word_valid=0, underflow=0, mem_read=0, mem_addr=FB_BASE, mem_byte_sel=0
  - internal: FIFO empty, state=IDLE, word counter=0
- FSM states: IDLE, FETCH, HOLD, DRAIN.
  - IDLE: waits for frame_start, then goes to FETCH.
  - FETCH: mem_read=1 with mem_addr. On mem_ack:
    - mem_rdata is pushed into the FIFO.
    - The address increments. After WORDS_PER_FRAME words it wraps to FB_BASE and the counter returns to 0.
    - If the FIFO is then full (count==FIFO_DEPTH, after any same-cycle pop), go to HOLD; otherwise stay in FETCH and keep mem_read high.
  - HOLD: mem_read=0. Return to FETCH on the cycle after count drops below FIFO_DEPTH.
  - DRAIN: entered when frame_start arrives while a request is outstanding (FETCH with no ack yet).
    - mem_read stays asserted until mem_ack; that data is discarded.
    - Then go to FETCH with mem_addr=FB_BASE.
- frame_start in FETCH with mem_ack in the same cycle: the acked data is discarded. Then:
  - FIFO flushed, address set to FB_BASE, counter cleared, underflow cleared.
  - Next state is FETCH.
- frame_start in IDLE or HOLD: flush and restart the same way, then go to FETCH.
- FIFO rules:
  - Push happens only on an accepted mem_ack.
  - Pop happens on pix_req && word_valid.
  - Simultaneous push and pop when full is legal; count is unchanged.
  - Simultaneous push and pop when empty: the pop is an underflow. The pushed word lands and word_valid=1 next cycle.
- Latency: a word pushed into an empty FIFO appears on word_out/word_valid one cycle after mem_ack.
- word_out holds its last value when the FIFO is empty.
- Pointer math: log2(FIFO_DEPTH)-bit pointers with natural wrap, plus a count of width log2(FIFO_DEPTH)+1.
- Address math: the ADDR_W-bit increment never overflows, because wrap happens at FB_BASE+WORDS_PER_FRAME-1.
- Reset asserted mid-operation returns everything to the reset values immediately. Outstanding SRAM data is ignored.

Optional Feature:
- Macro: VGA_PREFETCH_STATS_EN.
- Defined:
  - Adds output underflow_count [15:0], which increments on every underflowing pix_req and saturates at 16'hFFFF.
  - Adds output frame_count [15:0], which increments on each frame_start and wraps.
  - Both reset to 0.
  - underflow_count is cleared by frame_start. If an underflow and frame_start coincide, the count becomes 1.
- Undefined: neither port exists, and there is no counter logic.

Decomposition:
- Package vga_pkg:
  - typedef enum logic [1:0] prefetch_state_t {IDLE, FETCH, HOLD, DRAIN}
  - localparam FB_BASE_DEFAULT = 32'h3E80
  - localparam BYTE_SEL_ALL = 4'b1111
- Sub-module vga_word_fifo, parametrised by DATA_W and FIFO_DEPTH:
  - ports: push/pop/flush, full/empty, count, registered head output
  - instantiated once.

Test Plan:
- Reset, frame_start, mem_ack held high, no pix_req → addresses FB_BASE..FB_BASE+3 are read, FIFO full at count 4, mem_read=0 (HOLD). A single pix_req returns word_out = data of FB_BASE, and one more read is issued at FB_BASE+4.
- SRAM returns the value equal to its address; pix_req every 4th cycle over 9602 words → word_out sequence FB_BASE..FB_BASE+9599, then FB_BASE, FB_BASE+1 (wrap). underflow stays 0.
- After the first word is consumed with the FIFO empty and mem_ack withheld, assert pix_req → underflow=1 next cycle and word_out unchanged. A later frame_start clears underflow.
- frame_start while a read to FB_BASE+7 is outstanding, ack arriving 3 cycles later with 32'hDEAD → DEAD is never presented. The next read address is FB_BASE, and word_valid=0 until that ack.
- With FIFO full, pix_req and mem_ack in the same cycle → count stays 4 and the word order is preserved.
- With VGA_PREFETCH_STATS_EN defined, 3 underflowing pix_req → underflow_count=3; then frame_start → underflow_count=0 and frame_count increments by 1.
